calc_controller: RTL and testbench

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_controller.sv | 214 +++++++++++++++++++++
 tb/tb_calc_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_controller.sv
// calc_controller: keypad sequencer feeding a two-operand calculator datapath; CALC_CHAIN_EN adds result chaining.
// Latency: equals -> EXEC -> CAPTURE (done) -> RESULT; no backpressure, one key per cycle, only clear accepted while busy.
module calc_controller #(
  parameter int MAX_DIGITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key,
  output logic [6:0]  In1,
  output logic [6:0]  In2,
  output logic [3:0]  keyboard,
  input  logic [31:0] answer,
  input  logic        signal,
  output logic [31:0] disp_value,
  output logic        disp_neg,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_DIGITS);

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_BS  = 4'd15;

  typedef enum logic [2:0] {
    ENTER1  = 3'd0,
    ENTER2  = 3'd1,
    EXEC    = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [6:0]    op1, op1_nx;
  logic [6:0]    op2, op2_nx;
  logic [CW-1:0] cnt1, cnt1_nx;
  logic [CW-1:0] cnt2, cnt2_nx;
  logic [3:0]    op, op_nx;
  logic [31:0]   res, res_nx;
  logic          res_neg, res_neg_nx;

  logic key_digit;
  logic key_op;

  // Operands never exceed 10**MAX_DIGITS-1, so 7-bit arithmetic is exact
  // for the default build.
  function automatic logic [6:0] push_digit(input logic [6:0] v, input logic [3:0] d);
    return v * 7'd10 + {3'b000, d};
  endfunction

  function automatic logic [6:0] pop_digit(input logic [6:0] v);
    return v / 7'd10;
  endfunction

  function automatic logic [CW-1:0] cnt_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  assign key_digit = (key <= 4'd9);
  assign key_op    = (key == K_ADD) || (key == K_SUB) || (key == K_MUL);

`ifdef CALC_CHAIN_EN
  logic chain_ok;
  assign chain_ok = !res_neg && (res <= 32'd99);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ENTER1;
      op1     <= '0;
      op2     <= '0;
      cnt1    <= '0;
      cnt2    <= '0;
      op      <= '0;
      res     <= '0;
      res_neg <= 1'b0;
    end else begin
      state   <= state_nx;
      op1     <= op1_nx;
      op2     <= op2_nx;
      cnt1    <= cnt1_nx;
      cnt2    <= cnt2_nx;
      op      <= op_nx;
      res     <= res_nx;
      res_neg <= res_neg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    op1_nx     = op1;
    op2_nx     = op2;
    cnt1_nx    = cnt1;
    cnt2_nx    = cnt2;
    op_nx      = op;
    res_nx     = res;
    res_neg_nx = res_neg;

    // Clear wins over everything, including an in-flight calculation.
    if (key_valid && key == K_CLR) begin
      op1_nx     = '0;
      op2_nx     = '0;
      cnt1_nx    = '0;
      cnt2_nx    = '0;
      op_nx      = '0;
      res_nx     = '0;
      res_neg_nx = 1'b0;
      state_nx   = ENTER1;
    end else begin
      case (state)
        ENTER1: begin
          if (key_valid) begin
            if (key_digit) begin
              if (cnt1 < CMAX) begin
                op1_nx  = push_digit(op1, key);
                cnt1_nx = cnt1 + CW'(1);
              end
            end else if (key == K_BS) begin
              op1_nx  = pop_digit(op1);
              cnt1_nx = cnt_dec(cnt1);
            end else if (key_op) begin
              op_nx    = key;
              op2_nx   = '0;
              cnt2_nx  = '0;
              state_nx = ENTER2;
            end
          end
        end
        ENTER2: begin
          if (key_valid) begin
            if (key_digit) begin
              if (cnt2 < CMAX) begin
                op2_nx  = push_digit(op2, key);
                cnt2_nx = cnt2 + CW'(1);
              end
            end else if (key == K_BS) begin
              op2_nx  = pop_digit(op2);
              cnt2_nx = cnt_dec(cnt2);
            end else if (key_op) begin
              op_nx = key;
            end else if (key == K_EQ) begin
              state_nx = EXEC;
            end
          end
        end
        EXEC: begin
          state_nx = CAPTURE;
        end
        CAPTURE: begin
          res_nx     = answer;
          res_neg_nx = signal;
          state_nx   = RESULT;
        end
        RESULT: begin
          if (key_valid) begin
            if (key_digit) begin
              op1_nx   = {3'b000, key};
              cnt1_nx  = CW'(1);
              op2_nx   = '0;
              cnt2_nx  = '0;
              op_nx    = '0;
              state_nx = ENTER1;
            end
`ifdef CALC_CHAIN_EN
            else if (key_op && chain_ok) begin
              // Chained result is treated as a full operand: no further digits append.
              op1_nx   = res[6:0];
              cnt1_nx  = CMAX;
              op_nx    = key;
              op2_nx   = '0;
              cnt2_nx  = '0;
              state_nx = ENTER2;
            end
`endif
          end
        end
        default: begin
          state_nx = ENTER1;
        end
      endcase
    end
  end

  always_comb begin
    busy       = (state == EXEC) || (state == CAPTURE);
    done       = (state == CAPTURE);
    keyboard   = busy ? op : 4'd0;
    In1        = op1;
    In2        = op2;
    disp_value = res;
    disp_neg   = res_neg;
    case (state)
      ENTER1: begin
        disp_value = {25'd0, op1};
        disp_neg   = 1'b0;
      end
      ENTER2: begin
        disp_value = {25'd0, op2};
        disp_neg   = 1'b0;
      end
      default: begin
        disp_value = res;
        disp_neg   = res_neg;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: behavioural datapath plus result scoreboard keyed on done.
module tb_calc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key = 4'd0;
  logic [6:0]  In1, In2;
  logic [3:0]  keyboard;
  logic [31:0] answer;
  logic        signal;
  logic [31:0] disp_value;
  logic        disp_neg, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic done_d = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] e;

  calc_controller #(.MAX_DIGITS(2)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key(key),
    .In1(In1), .In2(In2), .keyboard(keyboard),
    .answer(answer), .signal(signal),
    .disp_value(disp_value), .disp_neg(disp_neg), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Calculator datapath stand-in: sign/magnitude result of In1 op In2.
  always_comb begin
    answer = 32'd0;
    signal = 1'b0;
    case (keyboard)
      4'd10: answer = 32'(In1) + 32'(In2);
      4'd11: begin
        if (In1 >= In2) answer = 32'(In1) - 32'(In2);
        else begin
          answer = 32'(In2) - 32'(In1);
          signal = 1'b1;
        end
      end
      4'd12: answer = 32'(In1) * 32'(In2);
      default: answer = 32'd0;
    endcase
  end

  // Scoreboard: the cycle after done, the registered result must match the oldest expectation.
  always @(negedge clk) begin
    if (done_d) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: result %0d neg %0d, nothing expected", disp_value, disp_neg);
      end else begin
        e = exp_q.pop_front();
        if ({disp_neg, disp_value} !== e) begin
          n_bad++;
          $display("FAIL sb_result: got %0d neg %0d, want %0d neg %0d", disp_value, disp_neg, e[31:0], e[32]);
        end
      end
    end
    done_d = (done === 1'b1);
    if (done === 1'b1) done_cnt++;
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key = k;
    @(negedge clk);
    key_valid = 1'b0;
    key = 4'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (In1 !== 7'd0) begin n_bad++; $display("FAIL reset_in1: got %0d want 0", In1); end
    n_cmp++; if (In2 !== 7'd0) begin n_bad++; $display("FAIL reset_in2: got %0d want 0", In2); end
    n_cmp++; if (keyboard !== 4'd0) begin n_bad++; $display("FAIL reset_keyboard: got %0d want 0", keyboard); end
    n_cmp++; if (disp_value !== 32'd0) begin n_bad++; $display("FAIL reset_disp: got %0d want 0", disp_value); end
    n_cmp++; if (disp_neg !== 1'b0) begin n_bad++; $display("FAIL reset_neg: got %0d want 0", disp_neg); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0d want 0", done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    press(4'd4);
    n_cmp++; if (disp_value !== 32'd4) begin n_bad++; $display("FAIL add_d1: got %0d want 4", disp_value); end
    press(4'd2);
    n_cmp++; if (disp_value !== 32'd42) begin n_bad++; $display("FAIL add_d2: got %0d want 42", disp_value); end
    press(4'd10);
    n_cmp++; if (disp_value !== 32'd0) begin n_bad++; $display("FAIL add_enter2: got %0d want 0", disp_value); end
    press(4'd1);
    press(4'd7);
    n_cmp++; if (disp_value !== 32'd17) begin n_bad++; $display("FAIL add_op2: got %0d want 17", disp_value); end
    exp_q.push_back({1'b0, 32'd59});
    press(4'd14);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL add_exec_busy: got %0d want 1", busy); end
    n_cmp++; if (keyboard !== 4'd10) begin n_bad++; $display("FAIL add_exec_kb: got %0d want 10", keyboard); end
    n_cmp++; if (In1 !== 7'd42) begin n_bad++; $display("FAIL add_exec_in1: got %0d want 42", In1); end
    n_cmp++; if (In2 !== 7'd17) begin n_bad++; $display("FAIL add_exec_in2: got %0d want 17", In2); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_exec_done: got %0d want 0", done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL add_done_n2: got %0d want 1", done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse: got %0d want 0", done); end
    n_cmp++; if (keyboard !== 4'd0) begin n_bad++; $display("FAIL add_result_kb: got %0d want 0", keyboard); end
    n_cmp++; if (In1 !== 7'd42) begin n_bad++; $display("FAIL add_hold_in1: got %0d want 42", In1); end
    n_cmp++; if (disp_value !== 32'd59) begin n_bad++; $display("FAIL add_result: got %0d want 59", disp_value); end
  endtask

  task automatic test_sub;
    press(4'd13);
    n_cmp++; if (disp_value !== 32'd0) begin n_bad++; $display("FAIL sub_clear: got %0d want 0", disp_value); end
    press(4'd5);
    press(4'd11);
    press(4'd9);
    exp_q.push_back({1'b1, 32'd4});
    press(4'd14);
    n_cmp++; if (keyboard !== 4'd11) begin n_bad++; $display("FAIL sub_exec_kb: got %0d want 11", keyboard); end
    repeat (2) @(negedge clk);
    n_cmp++; if (disp_neg !== 1'b1) begin n_bad++; $display("FAIL sub_neg: got %0d want 1", disp_neg); end
  endtask

  task automatic test_digits;
    press(4'd13);
    press(4'd9);
    press(4'd9);
    press(4'd9);
    n_cmp++; if (disp_value !== 32'd99) begin n_bad++; $display("FAIL dig_limit: got %0d want 99", disp_value); end
    press(4'd15);
    n_cmp++; if (disp_value !== 32'd9) begin n_bad++; $display("FAIL dig_bs: got %0d want 9", disp_value); end
    press(4'd1);
    n_cmp++; if (In1 !== 7'd91) begin n_bad++; $display("FAIL dig_91: got %0d want 91", In1); end
    press(4'd15);
    press(4'd15);
    press(4'd15);
    n_cmp++; if (disp_value !== 32'd0) begin n_bad++; $display("FAIL dig_bs_floor: got %0d want 0", disp_value); end
    press(4'd3);
    press(4'd4);
    press(4'd5);
    n_cmp++; if (disp_value !== 32'd34) begin n_bad++; $display("FAIL dig_recount: got %0d want 34", disp_value); end
    press(4'd14);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dig_eq_ignored_busy: got %0d want 0", busy); end
    n_cmp++; if (disp_value !== 32'd34) begin n_bad++; $display("FAIL dig_eq_ignored_disp: got %0d want 34", disp_value); end
  endtask

  task automatic test_op_replace;
    press(4'd13);
    press(4'd8);
    press(4'd10);
    press(4'd11);
    n_cmp++; if (disp_value !== 32'd0) begin n_bad++; $display("FAIL rep_enter2: got %0d want 0", disp_value); end
    press(4'd3);
    exp_q.push_back({1'b0, 32'd5});
    press(4'd14);
    n_cmp++; if (keyboard !== 4'd11) begin n_bad++; $display("FAIL rep_kb: got %0d want 11", keyboard); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mul_big;
    press(4'd13);
    press(4'd1);
    press(4'd2);
    press(4'd12);
    press(4'd9);
    press(4'd9);
    exp_q.push_back({1'b0, 32'd1188});
    press(4'd14);
    n_cmp++; if (keyboard !== 4'd12) begin n_bad++; $display("FAIL mul_kb: got %0d want 12", keyboard); end
    repeat (2) @(negedge clk);
    press(4'd10);
    n_cmp++; if (disp_value !== 32'd1188) begin n_bad++; $display("FAIL mul_add_ignored: got %0d want 1188", disp_value); end
    press(4'd15);
    n_cmp++; if (disp_value !== 32'd1188) begin n_bad++; $display("FAIL mul_bs_ignored: got %0d want 1188", disp_value); end
    press(4'd14);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mul_eq_ignored: got busy %0d want 0", busy); end
    n_cmp++; if (disp_value !== 32'd1188) begin n_bad++; $display("FAIL mul_eq_disp: got %0d want 1188", disp_value); end
  endtask

  task automatic test_chain;
    press(4'd13);
    press(4'd6);
    press(4'd12);
    press(4'd7);
    exp_q.push_back({1'b0, 32'd42});
    press(4'd14);
    repeat (2) @(negedge clk);
    press(4'd10);
`ifdef CALC_CHAIN_EN
    n_cmp++; if (disp_value !== 32'd0) begin n_bad++; $display("FAIL chain_enter2: got %0d want 0", disp_value); end
    press(4'd1);
    n_cmp++; if (disp_value !== 32'd1) begin n_bad++; $display("FAIL chain_op2: got %0d want 1", disp_value); end
    exp_q.push_back({1'b0, 32'd43});
    press(4'd14);
    n_cmp++; if (In1 !== 7'd42) begin n_bad++; $display("FAIL chain_in1: got %0d want 42", In1); end
    n_cmp++; if (keyboard !== 4'd10) begin n_bad++; $display("FAIL chain_kb: got %0d want 10", keyboard); end
    repeat (2) @(negedge clk);
`else
    n_cmp++; if (disp_value !== 32'd42) begin n_bad++; $display("FAIL nochain_hold: got %0d want 42", disp_value); end
    press(4'd1);
    n_cmp++; if (disp_value !== 32'd1) begin n_bad++; $display("FAIL nochain_newcalc: got %0d want 1", disp_value); end
    press(4'd14);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nochain_eq_ignored: got busy %0d want 0", busy); end
    n_cmp++; if (disp_value !== 32'd1) begin n_bad++; $display("FAIL nochain_eq_disp: got %0d want 1", disp_value); end
`endif
  endtask

  task automatic test_back_to_back;
    press(4'd13);
    press(4'd2);
    press(4'd10);
    press(4'd3);
    exp_q.push_back({1'b0, 32'd5});
    press(4'd14);
    key_valid = 1'b1;
    key = 4'd7;
    @(negedge clk);
    key_valid = 1'b0;
    key = 4'd0;
    n_cmp++; if (In2 !== 7'd3) begin n_bad++; $display("FAIL b2b_busy_digit: In2 got %0d want 3", In2); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %0d want 1", done); end
    @(negedge clk);
    press(4'd8);
    n_cmp++; if (disp_value !== 32'd8) begin n_bad++; $display("FAIL b2b_newcalc: got %0d want 8", disp_value); end
    n_cmp++; if (In2 !== 7'd0) begin n_bad++; $display("FAIL b2b_in2_cleared: got %0d want 0", In2); end
  endtask

  task automatic test_clear_busy;
    int c0;
    press(4'd13);
    press(4'd2);
    press(4'd10);
    press(4'd3);
    c0 = done_cnt;
    press(4'd14);
    key_valid = 1'b1;
    key = 4'd13;
    @(negedge clk);
    key_valid = 1'b0;
    key = 4'd0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy: got %0d want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL clr_done: got %0d want 0", done); end
    n_cmp++; if (In1 !== 7'd0) begin n_bad++; $display("FAIL clr_in1: got %0d want 0", In1); end
    n_cmp++; if (keyboard !== 4'd0) begin n_bad++; $display("FAIL clr_kb: got %0d want 0", keyboard); end
    repeat (3) @(negedge clk);
    n_cmp++; if (done_cnt !== c0) begin n_bad++; $display("FAIL clr_no_done: got %0d pulses want %0d", done_cnt, c0); end
  endtask

  task automatic test_reset_exec;
    int c0;
    press(4'd13);
    press(4'd3);
    press(4'd10);
    press(4'd4);
    c0 = done_cnt;
    press(4'd14);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %0d want 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (In1 !== 7'd0) begin n_bad++; $display("FAIL rst_in1: got %0d want 0", In1); end
    n_cmp++; if (In2 !== 7'd0) begin n_bad++; $display("FAIL rst_in2: got %0d want 0", In2); end
    n_cmp++; if (keyboard !== 4'd0) begin n_bad++; $display("FAIL rst_kb: got %0d want 0", keyboard); end
    n_cmp++; if (disp_value !== 32'd0) begin n_bad++; $display("FAIL rst_disp: got %0d want 0", disp_value); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0d want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0d want 0", done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (done_cnt !== c0) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want %0d", done_cnt, c0); end
    press(4'd5);
    n_cmp++; if (disp_value !== 32'd5) begin n_bad++; $display("FAIL rst_resume: got %0d want 5", disp_value); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_digits();
    test_op_replace();
    test_mul_big();
    test_chain();
    test_back_to_back();
    test_clear_busy();
    test_reset_exec();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_pending: got %0d results outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
